spi_req_arbiter: RTL

- Shares one spi_master between NUM_REQ requesters.
- Selects a requester by round-robin arbitration.
- Presents the selected requester's 32-bit word to the master via trigger/din, then tracks the master's cs to detect frame completion.
- Returns a per-requester done pulse. Sits between client logic and the spi_master instance, in front of the master/slave pair.

---
 rtl/spi_req_arbiter.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : spi_req_arbiter
//  Purpose  : Round-robin sharing of one spi_master among NUM_REQ requesters;
//             launches the granted word, tracks cs, returns a done pulse.
//             Optional cs-wait timeout enabled by macro SPI_ARB_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_req_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*DW-1:0] req_data,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    done,
    output logic                  err,
    output logic                  busy,
    output logic                  spi_trigger,
    output logic [DW-1:0]         spi_din,
    input  logic                  spi_cs
);

    localparam int               IDX_W    = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_LOW  = 3'd2,
        ST_WAIT_HIGH = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   last_gnt_q, last_gnt_d;
    logic [DW-1:0]      din_q, din_d;
    logic               trig_q, trig_d;
    logic               busy_q, busy_d;

    logic               arb_found;
    logic [IDX_W-1:0]   arb_idx;
    logic [IDX_W-1:0]   arb_cand;
    logic [DW-1:0]      arb_data;
    logic               go_done;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int               CNT_W   = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             go_abort;
    logic             cnt_expired;
`endif

    if ((NUM_REQ < 2) || (NUM_REQ > 8) || (DW < 1) || (TIMEOUT_CYC < 2)) begin : g_bad_params
        $error("spi_req_arbiter: parameter out of range");
    end

    // Scan upward from the slot after the last winner so the previous owner ranks last.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = last_gnt_q;
        arb_cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            arb_cand = IDX_W'((int'(last_gnt_q) + k) % NUM_REQ);
            if (!arb_found && req[arb_cand]) begin
                arb_found = 1'b1;
                arb_idx   = arb_cand;
            end
        end
    end

    always_comb begin
        arb_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (arb_idx == IDX_W'(k)) begin
                arb_data = req_data[k*DW +: DW];
            end
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    // Budget spans both wait states; it saturates so an exhausted budget stays exhausted.
    always_comb begin
        cnt_expired = (cnt_q == CNT_MAX);
        cnt_d       = cnt_q;
        if (state_q == ST_LAUNCH) begin
            cnt_d = '0;
        end else if (((state_q == ST_WAIT_LOW) || (state_q == ST_WAIT_HIGH)) && !cnt_expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        idx_d      = idx_q;
        last_gnt_d = last_gnt_q;
        din_d      = din_q;
        done_d     = '0;
        trig_d     = 1'b0;
        go_done    = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
        go_abort   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    state_d        = ST_LAUNCH;
                    idx_d          = arb_idx;
                    gnt_d          = '0;
                    gnt_d[arb_idx] = 1'b1;
                    din_d          = arb_data;
                    trig_d         = 1'b1;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!spi_cs) begin
                    state_d = ST_WAIT_HIGH;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (cnt_expired) begin
                    go_done  = 1'b1;
                    go_abort = 1'b1;
                end
`endif
            end
            ST_WAIT_HIGH: begin
                if (spi_cs) begin
                    go_done = 1'b1;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (cnt_expired) begin
                    go_done  = 1'b1;
                    go_abort = 1'b1;
                end
`endif
            end
            ST_DONE: begin
                last_gnt_d = idx_q;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (go_done) begin
            state_d       = ST_DONE;
            gnt_d         = '0;
            done_d[idx_q] = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
`ifdef SPI_ARB_TIMEOUT_EN
        err_d  = go_abort;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            done_q     <= '0;
            idx_q      <= '0;
            last_gnt_q <= LAST_RST;
            din_q      <= '0;
            trig_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            idx_q      <= idx_d;
            last_gnt_q <= last_gnt_d;
            din_q      <= din_d;
            trig_q     <= trig_d;
            busy_q     <= busy_d;
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign spi_trigger = trig_q;
    assign spi_din     = din_q;

endmodule
`default_nettype wire
